// File: rtl/systemizer_host_port_pkg.sv
// Shared definitions for the systemizer host port: matrix geometry, derived
// memory word/address widths, FSM state encoding and the element-legality test.
package systemizer_host_port_pkg;

    localparam int L     = 8;
    localparam int K     = 16;
    localparam int M     = 3;
    localparam int BLOCK = 4;

    localparam int EW    = $clog2(M);
    localparam int WW    = BLOCK * EW;
    localparam int WORDS = (L * K) / BLOCK;
    localparam int AW    = $clog2(WORDS);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } state_t;

    function automatic logic elem_legal(input logic [EW-1:0] e);
        return (int'(e) < M);
    endfunction

endpackage

// File: rtl/sysport_word_check.sv
// Sanitizes one packed matrix word: any element outside 0..M-1 is replaced by
// zero and the illegal flag is raised.
module sysport_word_check
    import systemizer_host_port_pkg::*;
(
    input  logic [WW-1:0] word,
    output logic [WW-1:0] clean,
    output logic          illegal
);

    always_comb begin
        clean   = word;
        illegal = 1'b0;
        for (int j = 0; j < BLOCK; j++) begin
            if (!elem_legal(word[j*EW +: EW])) begin
                clean[j*EW +: EW] = '0;
                illegal           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/systemizer_host_port.sv
// Host-side loader/unloader for the systemizer matrix memory: streams words in,
// pulses start, waits for done, then streams the result words back out.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for cmd_load; sticky flags hold their last value
// ST_LOAD   | in_ready high, each accepted word written one cycle later
// ST_START  | one-cycle sys_start pulse issued on leaving this state
// ST_WAIT   | waiting for sys_done; fail returns to idle, success unloads
// ST_UNLOAD | reads memory word by word into the single output register
module systemizer_host_port
    import systemizer_host_port_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_load,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          load_err,
    output logic          result_ok,
    output logic          result_fail,
    output logic          sys_wr_en,
    output logic [AW-1:0] sys_wr_addr,
    output logic [WW-1:0] sys_data_in,
    output logic          sys_start,
    input  logic          sys_done,
    input  logic          sys_fail,
    input  logic          sys_success,
    output logic          sys_rd_en,
    output logic [AW-1:0] sys_rd_addr,
    input  logic [WW-1:0] sys_data_out
);

    state_t        state;
    logic [AW-1:0] ctr;
    logic          rd_pend;
    logic          rd_last_pend;
    logic          rd_all;

    logic [WW-1:0] word_clean;
    logic          word_bad;
    logic          accept;
    logic          out_take;

    sysport_word_check u_word_check (
        .word    (in_data),
        .clean   (word_clean),
        .illegal (word_bad)
    );

    assign accept      = (state == ST_LOAD) && in_valid && in_ready;
    assign out_take    = out_valid && out_ready;
    assign busy        = (state != ST_IDLE);
    assign sys_rd_addr = ctr;

    // Only one read is ever in flight, and it is issued only when the output
    // register is free by the next edge, so returning data can never collide
    // with an unaccepted word. Looking at out_ready here gives 1 word / 2 cycles.
    assign sys_rd_en = (state == ST_UNLOAD) && !rd_pend && !rd_all &&
                       (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ctr          <= '0;
            rd_pend      <= 1'b0;
            rd_last_pend <= 1'b0;
            rd_all       <= 1'b0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            load_err     <= 1'b0;
            result_ok    <= 1'b0;
            result_fail  <= 1'b0;
            sys_wr_en    <= 1'b0;
            sys_wr_addr  <= '0;
            sys_data_in  <= '0;
            sys_start    <= 1'b0;
        end else begin
            sys_wr_en <= 1'b0;
            sys_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_load) begin
                        state       <= ST_LOAD;
                        in_ready    <= 1'b1;
                        ctr         <= '0;
                        load_err    <= 1'b0;
                        result_ok   <= 1'b0;
                        result_fail <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        sys_wr_en   <= 1'b1;
                        sys_wr_addr <= ctr;
                        sys_data_in <= word_clean;
                        if (word_bad) begin
                            load_err <= 1'b1;
                        end
                        if (ctr == LAST_ADDR) begin
                            in_ready <= 1'b0;
                            state    <= ST_START;
                        end else begin
                            ctr <= ctr + 1'b1;
                        end
                    end
                end

                ST_START: begin
                    sys_start <= 1'b1;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (sys_done) begin
                        if (sys_fail) begin
                            result_fail <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            result_ok <= sys_success;
                            ctr       <= '0;
                            rd_all    <= 1'b0;
                            state     <= ST_UNLOAD;
                        end
                    end
                end

                ST_UNLOAD: begin
                    rd_pend <= sys_rd_en;
                    if (sys_rd_en) begin
                        rd_last_pend <= (ctr == LAST_ADDR);
                        if (ctr == LAST_ADDR) begin
                            rd_all <= 1'b1;
                        end else begin
                            ctr <= ctr + 1'b1;
                        end
                    end
                    if (rd_pend) begin
                        out_valid <= 1'b1;
                        out_data  <= sys_data_out;
                        out_last  <= rd_last_pend;
                    end else if (out_take) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systemizer_host_port.sv
// Scoreboard bench for systemizer_host_port: stimulus queues expected writes,
// result words and status snapshots; a negedge monitor pops and compares.
module tb_systemizer_host_port;
    import systemizer_host_port_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_load = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          load_err;
    logic          result_ok;
    logic          result_fail;
    logic          sys_wr_en;
    logic [AW-1:0] sys_wr_addr;
    logic [WW-1:0] sys_data_in;
    logic          sys_start;
    logic          sys_done = 1'b0;
    logic          sys_fail = 1'b0;
    logic          sys_success = 1'b0;
    logic          sys_rd_en;
    logic [AW-1:0] sys_rd_addr;
    logic [WW-1:0] sys_data_out = '0;

    systemizer_host_port dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_load     (cmd_load),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .load_err     (load_err),
        .result_ok    (result_ok),
        .result_fail  (result_fail),
        .sys_wr_en    (sys_wr_en),
        .sys_wr_addr  (sys_wr_addr),
        .sys_data_in  (sys_data_in),
        .sys_start    (sys_start),
        .sys_done     (sys_done),
        .sys_fail     (sys_fail),
        .sys_success  (sys_success),
        .sys_rd_en    (sys_rd_en),
        .sys_rd_addr  (sys_rd_addr),
        .sys_data_out (sys_data_out)
    );

    always #5 clk = ~clk;

    typedef enum {K_BUSY, K_LOAD_ERR, K_RES_OK, K_RES_FAIL, K_IN_READY,
                  K_OUTS_ZERO, K_STARTS, K_RDS, K_WQ_EMPTY, K_OQ_EMPTY,
                  K_TIMEOUT} kind_t;
    typedef struct { kind_t kind; int exp; string name; } stat_t;
    typedef struct { int addr; int data; } wexp_t;
    typedef struct { int data; int last; } oexp_t;

    stat_t sq[$];
    wexp_t wq[$];
    oexp_t oq[$];

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_rd = 0;

    logic [WW-1:0] mem [WORDS];
    logic [WW-1:0] load_buf [WORDS];
    logic          preload_req = 1'b0;

    // Memory model: one-cycle read latency, preload writes word i = i.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= WW'(i);
        end else if (sys_wr_en) begin
            mem[sys_wr_addr] <= sys_data_in;
        end
        if (sys_rd_en) sys_data_out <= mem[sys_rd_addr];
    end

    function automatic logic [7:0] tb_clean(input logic [7:0] w);
        logic [7:0] r;
        r = w;
        if (w[1:0] == 2'd3) r[1:0] = 2'd0;
        if (w[3:2] == 2'd3) r[3:2] = 2'd0;
        if (w[5:4] == 2'd3) r[5:4] = 2'd0;
        if (w[7:6] == 2'd3) r[7:6] = 2'd0;
        return r;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard
    logic          hold_v = 1'b0;
    logic [WW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            wq.delete();
            oq.delete();
            hold_v = 1'b0;
        end else begin
            if (sys_start) n_start++;
            if (sys_rd_en) n_rd++;
            if (sys_wr_en || sys_rd_en || sys_start)
                cmp("strobe_excl", int'(sys_wr_en) + int'(sys_rd_en) + int'(sys_start), 1);

            if (sys_wr_en) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected addr=%0d data=0x%0h expected=none", sys_wr_addr, sys_data_in);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    cmp("wr_addr", int'(sys_wr_addr), w.addr);
                    cmp("wr_data", int'(sys_data_in), w.data);
                end
            end

            if (hold_v) begin
                cmp("stall_valid", int'(out_valid), 1);
                cmp("stall_data", int'(out_data), int'(hold_d));
                cmp("stall_last", int'(out_last), int'(hold_l));
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;

            if (out_valid && out_ready) begin
                if (oq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected data=0x%0h expected=none", out_data);
                end else begin
                    oexp_t o;
                    o = oq.pop_front();
                    cmp("out_data", int'(out_data), o.data);
                    cmp("out_last", int'(out_last), o.last);
                end
            end

            while (sq.size() > 0) begin
                stat_t s;
                int act;
                s = sq.pop_front();
                case (s.kind)
                    K_BUSY:      act = int'(busy);
                    K_LOAD_ERR:  act = int'(load_err);
                    K_RES_OK:    act = int'(result_ok);
                    K_RES_FAIL:  act = int'(result_fail);
                    K_IN_READY:  act = int'(in_ready);
                    K_OUTS_ZERO: act = int'({in_ready, out_valid, out_data, out_last, busy,
                                             load_err, result_ok, result_fail, sys_wr_en,
                                             sys_wr_addr, sys_data_in, sys_start, sys_rd_en,
                                             sys_rd_addr} == '0);
                    K_STARTS:    act = n_start;
                    K_RDS:       act = n_rd;
                    K_WQ_EMPTY:  act = int'(wq.size() == 0);
                    K_OQ_EMPTY:  act = int'(oq.size() == 0);
                    default:     act = 0;
                endcase
                cmp(s.name, act, s.exp);
            end
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input kind_t k, input int e, input string nm);
        stat_t s;
        s.kind = k;
        s.exp  = e;
        s.name = nm;
        sq.push_back(s);
    endtask

    task automatic pulse_cmd();
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < WORDS; i++) begin
            int g;
            wexp_t w;
            g = 0;
            in_valid = 1'b1;
            in_data  = load_buf[i];
            while (!in_ready && g < 50) begin
                tick();
                g++;
            end
            if (!in_ready) begin
                expect_st(K_TIMEOUT, 1, "timeout_load_ready");
                break;
            end
            w.addr = i;
            w.data = int'(tb_clean(load_buf[i]));
            wq.push_back(w);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int g;
        g = 0;
        while (!sys_start && g < 20) begin
            tick();
            g++;
        end
        if (!sys_start) expect_st(K_TIMEOUT, 1, "timeout_start");
    endtask

    task automatic pulse_done(input logic fail_v, input logic ok_v);
        sys_done    = 1'b1;
        sys_fail    = fail_v;
        sys_success = ok_v;
        tick();
        sys_done    = 1'b0;
        sys_fail    = 1'b0;
        sys_success = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        expect_st(K_OUTS_ZERO, 1, "reset_outputs_zero");
        tick();

        // A: words 0x00..0x1F, then systemizer reports fail
        for (int i = 0; i < WORDS; i++) load_buf[i] = 8'(i);
        pulse_cmd();
        expect_st(K_IN_READY, 1, "a_in_ready_load");
        expect_st(K_BUSY, 1, "a_busy_load");
        load_all();
        expect_st(K_IN_READY, 0, "a_in_ready_after_last");
        expect_st(K_LOAD_ERR, 1, "a_load_err");
        wait_start();
        repeat (10) tick();
        expect_st(K_STARTS, 1, "a_one_start");
        pulse_done(1'b1, 1'b0);
        expect_st(K_RES_FAIL, 1, "a_result_fail");
        expect_st(K_RES_OK, 0, "a_result_ok");
        expect_st(K_BUSY, 0, "a_busy_after_fail");
        // idle: stray done and in_valid must be ignored
        pulse_done(1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h11;
        repeat (3) tick();
        expect_st(K_IN_READY, 0, "idle_in_ready");
        in_valid = 1'b0;
        tick();
        expect_st(K_RES_OK, 0, "idle_done_ignored");
        expect_st(K_LOAD_ERR, 1, "idle_load_err_sticky");
        expect_st(K_RES_FAIL, 1, "idle_fail_sticky");
        expect_st(K_RDS, 0, "a_no_reads");
        expect_st(K_WQ_EMPTY, 1, "a_all_writes_seen");
        tick();

        // B: bad first word, WAIT-time noise, preloaded memory, stalled unload
        load_buf[0] = 8'hC0;
        for (int i = 1; i < WORDS; i++) load_buf[i] = 8'h40 | (8'(i) & 8'h22);
        pulse_cmd();
        expect_st(K_LOAD_ERR, 0, "b_load_err_cleared");
        expect_st(K_RES_FAIL, 0, "b_result_fail_cleared");
        load_all();
        expect_st(K_LOAD_ERR, 1, "b_load_err_set");
        wait_start();
        tick();
        cmd_load = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h15;
        repeat (3) tick();
        cmd_load = 1'b0;
        in_valid = 1'b0;
        expect_st(K_BUSY, 1, "b_busy_wait");
        expect_st(K_IN_READY, 0, "b_in_ready_wait");
        expect_st(K_STARTS, 2, "b_starts");
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            oexp_t o;
            o.data = i;
            o.last = (i == WORDS - 1) ? 1 : 0;
            oq.push_back(o);
        end
        pulse_done(1'b0, 1'b1);
        expect_st(K_RES_OK, 1, "b_result_ok");
        for (int c = 0; c < 600 && busy; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        if (busy) expect_st(K_TIMEOUT, 1, "timeout_unload");
        out_ready = 1'b0;
        expect_st(K_BUSY, 0, "b_busy_after_unload");
        expect_st(K_OQ_EMPTY, 1, "b_all_words_out");
        expect_st(K_RDS, 32, "b_read_count");
        expect_st(K_LOAD_ERR, 1, "b_load_err_sticky");
        expect_st(K_RES_FAIL, 0, "b_result_fail");
        tick();

        // C: reset while word 5 is presented
        load_buf[0] = 8'h40;
        pulse_cmd();
        load_all();
        wait_start();
        for (int i = 0; i < WORDS; i++) begin
            oexp_t o;
            o.data = int'(tb_clean(load_buf[i]));
            o.last = (i == WORDS - 1) ? 1 : 0;
            oq.push_back(o);
        end
        pulse_done(1'b0, 1'b1);
        out_ready = 1'b1;
        begin
            int acc;
            int c;
            acc = 0;
            for (c = 0; c < 300; c++) begin
                if (out_valid) begin
                    if (acc == 5) break;
                    acc++;
                end
                tick();
            end
            if (c == 300) expect_st(K_TIMEOUT, 1, "timeout_word5");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        expect_st(K_OUTS_ZERO, 1, "c_reset_outputs_zero");
        tick();
        expect_st(K_OUTS_ZERO, 1, "c_no_strobe_after_reset");
        tick();
        pulse_cmd();
        expect_st(K_IN_READY, 1, "c_restart_in_ready");
        expect_st(K_LOAD_ERR, 0, "c_restart_load_err");
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
